hps_reset_sequencer: RTL
========================

# hps_reset_sequencer

Sequencer and arbiter for the three HPS reset lines (cold, warm, debug). It accepts level reset requests from several requesters, such as the debounced push-buttons, the source/probe instance and a software CSR. It grants one request at a time by severity and round-robin, and drives a registered, fixed-length pulse on the matching reset line. A mandatory hold-off follows each pulse, so the HPS never sees overlapping or back-to-back resets.

## Interface
- NUM_REQ, 3, number of requesters (1..8)
- COLD_PULSE, 6, cold reset pulse length in clk cycles (≥1)
- WARM_PULSE, 2, warm reset pulse length (≥1)
- DEBUG_PULSE, 32, debug reset pulse length (≥1)
- HOLDOFF, 50000, quiet cycles after every pulse (≥2); at 50 MHz this is 1 ms
- CNT_WIDTH, 16, width of the shared down-counter; must hold max(all pulse lengths, HOLDOFF)−1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  level request per requester; held until acked
- req_type  in  2*NUM_REQ  2 bits per requester, [2i+1:2i]: 0=cold, 1=warm, 2=debug, 3=reserved
- req_ack  out  NUM_REQ  one-cycle grant pulse, one-hot or zero
- grant_id  out  3  index of the last granted requester
- hps_cold_reset  out  1  cold reset pulse, active high
- hps_warm_reset  out  1  warm reset pulse, active high
- hps_debug_reset  out  1  debug reset pulse, active high
- busy  out  1  high in PULSE and HOLDOFF
- err_reserved  out  1  one-cycle pulse when a reserved-type request is acked

## Operation
- States: IDLE, PULSE, HOLDOFF.
- **IDLE arbitration:**
  - Among valid requesters, the highest severity wins: cold > warm > debug > reserved.
  - Ties within a severity class go round-robin, starting at rr_ptr. rr_ptr then moves to winner+1, modulo NUM_REQ.
  - Only the winner is acked. Losers stay pending.
- **Grant of cold/warm/debug:**
  - req_ack[winner] pulses, grant_id updates, and the matching reset output goes high.
  - The counter loads (pulse length − 1) and the state moves to PULSE.
- **Grant of reserved:** ack plus err_reserved, no reset pulse, state remains IDLE.
- **PULSE:**
  - The counter decrements each cycle.
  - When the counter reaches 0, the output drops, the counter loads HOLDOFF−1 and the state moves to HOLDOFF.
- **Escalation:**
  - Applies in PULSE with a warm or debug pulse active when any valid cold request exists.
  - The round-robin cold winner is acked and the current output drops.
  - hps_cold_reset rises in the same cycle and the counter reloads COLD_PULSE−1.
  - Cold never escalates or restarts itself.
- **HOLDOFF:**
  - All reset outputs are low and no acks are issued, including for cold requests.
  - When the counter reaches 0, the state moves to IDLE.
- **Requester rule:** drop req_valid on the cycle after the ack. A request still held when the block returns to IDLE counts as a new request.
- **Reset values:** all outputs 0, grant_id 0, rr_ptr 0, counter 0, state IDLE.
- Asserting reset_n low mid-pulse immediately forces the reset outputs low. After release, the block restarts in IDLE.

## Timing
- All outputs are registered.
- **Grant latency:** requests are sampled at edge t in IDLE, and req_ack plus the reset output are high from cycle t+1.
- A pulse of length N is high during cycles t+1..t+N.
- HOLDOFF spans t+N+1..t+N+HOLDOFF. The next ack comes no earlier than t+N+HOLDOFF+2.
- At most one reset output is high in any cycle.
- **Escalation latency:** a cold request sampled at edge e produces the cold pulse over e+1..e+COLD_PULSE.
- **Simultaneous events:**
  - A request arriving at the same edge as HOLDOFF→IDLE is not granted until the following edge.
  - A cold request arriving at the last PULSE edge is not escalated; the block enters HOLDOFF.

## Structure
- Package hps_reset_pkg:
  - req_type_t enum: REQ_COLD, REQ_WARM, REQ_DEBUG, REQ_RSVD.
  - seq_state_t enum: IDLE, PULSE, HOLDOFF.
  - Pulse-length defaults as localparams.
- One sub-module, rr_arbiter. It is a parameterised combinational round-robin picker over a request mask and a pointer, producing a one-hot grant and an index. It is instantiated once per severity class, or once over a severity-filtered mask.

## Test plan
- **Single warm:** req0 warm at edge 10 -> ack0 at cycle 11, hps_warm_reset high cycles 11–12, busy until cycle 2+HOLDOFF+10.
- **Severity:** req0 debug and req2 cold raised together -> ack2 and a 6-cycle cold pulse first. Debug is acked only after the hold-off completes.
- **Round-robin:** req0, req1 and req2 all warm and held -> grants go 0, 1, 2, 0 in order, each separated by pulse + HOLDOFF.
- **Escalation:** req1 raises cold at cycle 10 of a 32-cycle debug pulse -> debug drops, cold is high for exactly 6 cycles, and no cycle has two outputs high.
- **Reserved and hold-off:**
  - A type-3 request gives ack plus err_reserved in the same cycle, no reset pulse, and busy stays 0.
  - A cold request raised during HOLDOFF is not acked until after IDLE is re-entered.
- **Async reset:** reset_n low at cycle 3 of a cold pulse -> all outputs 0 with no clock edge. After release, a held request is re-granted 1 cycle after the first sampling edge.

Source files
------------

// File: rtl/hps_reset_sequencer_pkg.sv
// Shared types and defaults for the HPS reset sequencer: request severity
// classes, sequencer states and the round-robin pointer helper.
package hps_reset_pkg;

    typedef enum logic [1:0] {
        REQ_COLD  = 2'd0,
        REQ_WARM  = 2'd1,
        REQ_DEBUG = 2'd2,
        REQ_RSVD  = 2'd3
    } req_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_COLD_PULSE  = 6;
    localparam int DEF_WARM_PULSE  = 2;
    localparam int DEF_DEBUG_PULSE = 32;
    localparam int DEF_HOLDOFF     = 50000;
    localparam int DEF_CNT_WIDTH   = 16;

    // Pointer position just after the winner, wrapping at the requester count.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/hps_reset_sequencer_if.sv
// Request/grant and reset-line bundle between the requesters and the sequencer.
interface hps_reset_sequencer_if
    import hps_reset_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_type;
    logic [NUM_REQ-1:0]   req_ack;
    logic [2:0]           grant_id;
    logic                 hps_cold_reset;
    logic                 hps_warm_reset;
    logic                 hps_debug_reset;
    logic                 busy;
    logic                 err_reserved;

    modport master (
        output req_valid, req_type,
        input  req_ack, grant_id, hps_cold_reset, hps_warm_reset,
               hps_debug_reset, busy, err_reserved
    );

    modport slave (
        input  req_valid, req_type,
        output req_ack, grant_id, hps_cold_reset, hps_warm_reset,
               hps_debug_reset, busy, err_reserved
    );
endinterface

// File: rtl/hps_reset_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// returned both one-hot and as an index.
module rr_arbiter
    import hps_reset_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/hps_reset_sequencer.sv
// Arbitrates level reset requests by severity then round-robin and drives one
// fixed-length registered reset pulse at a time, followed by a quiet hold-off.
module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int COLD_PULSE  = DEF_COLD_PULSE,
    parameter int WARM_PULSE  = DEF_WARM_PULSE,
    parameter int DEBUG_PULSE = DEF_DEBUG_PULSE,
    parameter int HOLDOFF_LEN = DEF_HOLDOFF,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hps_reset_sequencer_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CNT_WIDTH-1:0] COLD_LD  = CNT_WIDTH'(COLD_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] WARM_LD  = CNT_WIDTH'(WARM_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] DEBUG_LD = CNT_WIDTH'(DEBUG_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LD  = CNT_WIDTH'(HOLDOFF_LEN - 1);

    seq_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [IW-1:0]        r_ptr;
    logic [NUM_REQ-1:0]   r_ack;
    logic [2:0]           r_gid;
    logic                 r_cold;
    logic                 r_warm;
    logic                 r_debug;
    logic                 r_busy;
    logic                 r_err;

    logic [NUM_REQ-1:0]   w_cold_m;
    logic [NUM_REQ-1:0]   w_warm_m;
    logic [NUM_REQ-1:0]   w_debug_m;
    logic [NUM_REQ-1:0]   w_rsvd_m;
    logic [NUM_REQ-1:0]   w_mask;
    req_type_t            w_cls;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IW-1:0]        w_idx;
    logic                 w_any;
    logic [IW-1:0]        w_ptr_nxt;

    always_comb begin
        w_cold_m  = '0;
        w_warm_m  = '0;
        w_debug_m = '0;
        w_rsvd_m  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            case (req_type_t'(bus.req_type[2*i +: 2]))
                REQ_COLD:  w_cold_m[i]  = bus.req_valid[i];
                REQ_WARM:  w_warm_m[i]  = bus.req_valid[i];
                REQ_DEBUG: w_debug_m[i] = bus.req_valid[i];
                default:   w_rsvd_m[i]  = bus.req_valid[i];
            endcase
        end
    end

    // In IDLE the most severe populated class competes; during a warm/debug
    // pulse only cold requests may compete (escalation).
    always_comb begin
        w_cls  = REQ_RSVD;
        w_mask = '0;
        if (r_state == IDLE) begin
            if (|w_cold_m) begin
                w_cls  = REQ_COLD;
                w_mask = w_cold_m;
            end else if (|w_warm_m) begin
                w_cls  = REQ_WARM;
                w_mask = w_warm_m;
            end else if (|w_debug_m) begin
                w_cls  = REQ_DEBUG;
                w_mask = w_debug_m;
            end else begin
                w_cls  = REQ_RSVD;
                w_mask = w_rsvd_m;
            end
        end else if (r_state == PULSE && !r_cold) begin
            w_cls  = REQ_COLD;
            w_mask = w_cold_m;
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .i_req (w_mask),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_ptr_nxt = IW'(rr_next(int'(w_idx), NUM_REQ));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_gid   <= '0;
            r_cold  <= 1'b0;
            r_warm  <= 1'b0;
            r_debug <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ack <= w_gnt;
                        r_gid <= 3'(w_idx);
                        r_ptr <= w_ptr_nxt;
                        case (w_cls)
                            REQ_COLD: begin
                                r_cold  <= 1'b1;
                                r_cnt   <= COLD_LD;
                                r_busy  <= 1'b1;
                                r_state <= PULSE;
                            end
                            REQ_WARM: begin
                                r_warm  <= 1'b1;
                                r_cnt   <= WARM_LD;
                                r_busy  <= 1'b1;
                                r_state <= PULSE;
                            end
                            REQ_DEBUG: begin
                                r_debug <= 1'b1;
                                r_cnt   <= DEBUG_LD;
                                r_busy  <= 1'b1;
                                r_state <= PULSE;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                PULSE: begin
                    // Pulse end wins over a cold request arriving on the same edge.
                    if (r_cnt == '0) begin
                        r_cold  <= 1'b0;
                        r_warm  <= 1'b0;
                        r_debug <= 1'b0;
                        r_cnt   <= HOLD_LD;
                        r_state <= HOLDOFF;
                    end else if (w_any) begin
                        r_ack   <= w_gnt;
                        r_gid   <= 3'(w_idx);
                        r_ptr   <= w_ptr_nxt;
                        r_cold  <= 1'b1;
                        r_warm  <= 1'b0;
                        r_debug <= 1'b0;
                        r_cnt   <= COLD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack         = r_ack;
    assign bus.grant_id        = r_gid;
    assign bus.hps_cold_reset  = r_cold;
    assign bus.hps_warm_reset  = r_warm;
    assign bus.hps_debug_reset = r_debug;
    assign bus.busy            = r_busy;
    assign bus.err_reserved    = r_err;

endmodule
